// File: rtl/xps_pkg.sv
// Shared types and helpers for the xor_parity_sched block.
//   state_e : FSM encoding for the scheduler (idle / shifting / result cycle)
//   id_w()  : width of a requester index for a given requester count
package xps_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Index width for n requesters, never less than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans last_i+1, last_i+2, ... (mod NREQ) and selects the first set request.
// Ports:
//   req_i   : request vector
//   last_i  : index of the most recently granted requester
//   gnt_o   : one-hot selection (all zero when no request)
//   idx_o   : index of the selected requester
//   valid_o : at least one request present
module rr_pick
  import xps_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdW-1:0]  idx_o,
  output logic            valid_o
);

  logic           found;
  logic [IdW-1:0] pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    // i runs 1..NREQ so the last granted requester is checked last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      pos = IdW'((32'(last_i) + i) % NREQ);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/xor_cmos.sv
// Two-input XOR cell. Behavioural stand-in for the transistor-level xor_cmos
// cell so that the scheduler can be simulated and linted on its own.
// Ports:
//   a_i, b_i : operands
//   y_o      : a_i ^ b_i
module xor_cmos (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_parity_sched.sv
// Round-robin scheduler sharing one bit-serial XOR parity datapath among NREQ
// requesters. A granted word is captured, shifted LSB-first through an
// accumulator built on the xor_cmos cell, and the parity is returned together
// with the requester index.
//
// Build option: XPS_ODD_PARITY_EN -- when defined the accumulator starts at 1,
// giving odd parity (~^word); otherwise even parity (^word). Timing identical.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   req        : per-requester request level
//   data       : word i at data[i*WIDTH +: WIDTH]
//   gnt        : one-hot, one-cycle grant; the granted word is captured that cycle
//   busy       : high from the grant cycle through the done cycle
//   done       : one-cycle result pulse
//   done_id    : index of the requester just served (held until next done)
//   parity_out : parity of the served word (held until next done)
module xor_parity_sched
  import xps_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     parity_out
);

  localparam int unsigned IdW  = id_w(NREQ);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef XPS_ODD_PARITY_EN
  localparam logic AccInit = 1'b1;
`else
  localparam logic AccInit = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [IdW-1:0]   id_q, id_d;
  logic             par_q, par_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IdW-1:0]   pick_idx;
  logic             pick_valid;
  logic             acc_upd;

  rr_pick #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  xor_cmos u_xor (
    .a_i (acc_q),
    .b_i (shreg_q[0]),
    .y_o (acc_upd)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    par_d   = par_q;
    gnt     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // gnt is combinational from req, so mask it while reset is asserted.
        if (pick_valid && !rst) begin
          gnt     = pick_gnt;
          busy    = 1'b1;
          shreg_d = data[pick_idx*WIDTH +: WIDTH];
          acc_d   = AccInit;
          cnt_d   = CntW'(WIDTH);
          last_d  = pick_idx;
          state_d = StShift;
        end
      end
      StShift: begin
        busy    = 1'b1;
        acc_d   = acc_upd;
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          // Result registers load on the final bit so they are valid in StDone.
          par_d   = acc_upd;
          id_d    = last_q;
          state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IdW'(NREQ - 1);
      id_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      par_q   <= par_d;
    end
  end

  assign done_id    = id_q;
  assign parity_out = par_q;

endmodule

// File: tb/tb_xor_parity_sched.sv
// Directed bench for xor_parity_sched: a 4x8 instance for arbitration and
// parity, plus a 2x1 instance for the single-bit word case.
module tb_xor_parity_sched;

`ifdef XPS_ODD_PARITY_EN
  localparam logic OddBit = 1'b1;
`else
  localparam logic OddBit = 1'b0;
`endif

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [1:0]  done_id;
  logic        parity_out;

  logic        rst2;
  logic [1:0]  req2, data2, gnt2;
  logic        busy2, done2, par2;
  logic [0:0]  done_id2;

  xor_parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .parity_out (parity_out)
  );

  xor_parity_sched #(.NREQ(2), .WIDTH(1)) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .req        (req2),
    .data       (data2),
    .gnt        (gnt2),
    .busy       (busy2),
    .done       (done2),
    .done_id    (done_id2),
    .parity_out (par2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int last_gnt_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a grant, then follows the job to its done cycle.
  task automatic do_job(input string name, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                        input logic exp_par, input bit chk_space, input bit drop);
    int   waited = 0;
    int   t;
    logic [3:0] stray = '0;
    logic busy_ok = 1'b1;
    logic early = 1'b0;
    #1;
    while (gnt == 4'b0 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
    t = cyc;
    if (chk_space) check({name, " spacing"}, 32'(t - last_gnt_cyc), 32'(WIDTH + 2));
    last_gnt_cyc = t;
    busy_ok &= busy;
    for (int i = 1; i <= WIDTH + 1; i++) begin
      @(negedge clk); #1;
      if (drop && i == 1) begin
        req            = 4'b0;
        data[31:24]    = data[31:24] ^ 8'h01;
      end
      stray   |= gnt;
      busy_ok &= busy;
      if (i <= WIDTH) early |= done;
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " done_id"}, 32'(done_id), 32'(exp_id));
    check({name, " parity"}, 32'(parity_out), 32'(exp_par ^ OddBit));
    check({name, " early done"}, 32'(early), 32'd0);
    check({name, " stray gnt"}, 32'(stray), 32'd0);
    check({name, " busy"}, 32'(busy_ok), 32'd1);
  endtask

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        par;
    bit          space;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   tmo;
    logic dn;
    int   t0;

    tbl[0] = '{1'b1, 4'b0001, 32'h000000A5, 4'b0001, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, 32'h0F070301, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'b1111, 32'h0F070301, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 4'b1111, 32'h0F070301, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 4'b1111, 32'h0F070301, 4'b1000, 2'd3, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 4'b1111, 32'h0F070301, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 4'b0100, 32'h00800000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'b0100, 32'h00800000, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 4'b0100, 32'h00800000, 4'b0100, 2'd2, 1'b1, 1'b1};

    rst = 1'b1; req = '0; data = '0;
    rst2 = 1'b1; req2 = '0; data2 = '0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;

    // Tests 1-3: single request, full rotation, lone requester.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_before) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (i == 0) begin
          check("reset gnt", 32'(gnt), 32'd0);
          check("reset busy", 32'(busy), 32'd0);
          check("reset done", 32'(done), 32'd0);
          check("reset done_id", 32'(done_id), 32'd0);
          check("reset parity", 32'(parity_out), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
      end
      req  = tbl[i].req;
      data = tbl[i].data;
      do_job($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].par, tbl[i].space, 1'b0);
    end

    // Test 4: reset mid-job discards it; pointer reset leads to requester 1.
    req = 4'b0010;
    data[15:8] = 8'h3C;
    @(negedge clk); #1;
    check("t4 gnt", 32'(gnt), 32'b0010);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4 rst gnt", 32'(gnt), 32'd0);
    check("t4 rst busy", 32'(busy), 32'd0);
    check("t4 rst done", 32'(done), 32'd0);
    check("t4 rst done_id", 32'(done_id), 32'd0);
    check("t4 rst parity", 32'(parity_out), 32'd0);
    @(negedge clk);
    req = 4'b0;
    rst = 1'b0;
    dn  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      dn |= done;
    end
    check("t4 no done", 32'(dn), 32'd0);
    req = 4'b0010;
    do_job("t4 regrant", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);

    // Test 5: requester 3 withdraws and changes its word after the grant.
    req = 4'b1000;
    data[31:24] = 8'h0B;
    do_job("t5", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);

    // Test 6: WIDTH=1 instance, two requesters.
    @(negedge clk);
    req2 = 2'b11;
    data2 = 2'b10;
    #1;
    tmo = 0;
    while (gnt2 == 2'b0 && tmo < 10) begin
      @(negedge clk); #1;
      tmo++;
    end
    check("t6 gnt0", 32'(gnt2), 32'b01);
    @(negedge clk); #1;
    check("t6 shift no done", 32'(done2), 32'd0);
    @(negedge clk); #1;
    check("t6 done0", 32'(done2), 32'd1);
    check("t6 id0", 32'(done_id2), 32'd0);
    check("t6 par0", 32'(par2), 32'(1'b0 ^ OddBit));
    t0 = cyc;
    @(negedge clk); #1;
    check("t6 gnt1", 32'(gnt2), 32'b10);
    @(negedge clk);
    @(negedge clk); #1;
    check("t6 done1", 32'(done2), 32'd1);
    check("t6 id1", 32'(done_id2), 32'd1);
    check("t6 par1", 32'(par2), 32'(1'b1 ^ OddBit));
    check("t6 spacing", 32'(cyc - t0), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
